// File: rtl/bht_update_scheduler_pkg.sv
// Shared types and helpers for the branch history table update scheduler:
// 2-bit counter encodings, FSM state type and saturating counter arithmetic.
package bht_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_RD = 2'd1,
    UPD_WR = 2'd2
  } bht_state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    logic [1:0] r;
    case (ctr)
      CTR_SNT: r = CTR_WNT;
      CTR_WNT: r = CTR_WT;
      default: r = CTR_ST;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    logic [1:0] r;
    case (ctr)
      CTR_ST:  r = CTR_WT;
      CTR_WT:  r = CTR_WNT;
      default: r = CTR_SNT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bht_update_scheduler_if.sv
// Bundle of the lookup, update and table-port signals of the scheduler.
// master: the surrounding pipeline/table side; slave: the scheduler.
interface bht_update_scheduler_if #(
  parameter int unsigned ADDR_W = 5
) ();

  logic              lk_valid;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_ready;
  logic              pred_valid;
  logic              pred_taken;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_taken;
  logic              upd_ready;

  logic              tbl_en;
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_addr;
  logic [1:0]        tbl_wdata;
  logic [1:0]        tbl_rdata;

  modport master (
    output lk_valid, lk_addr, upd_valid, upd_addr, upd_taken, tbl_rdata,
    input  lk_ready, pred_valid, pred_taken, upd_ready,
           tbl_en, tbl_we, tbl_addr, tbl_wdata
  );

  modport slave (
    input  lk_valid, lk_addr, upd_valid, upd_addr, upd_taken, tbl_rdata,
    output lk_ready, pred_valid, pred_taken, upd_ready,
           tbl_en, tbl_we, tbl_addr, tbl_wdata
  );

endinterface

// File: rtl/bht_update_scheduler_fifo.sv
// Small FIFO holding pending {addr, taken} counter updates.
// Pointers carry one extra wrap bit to tell full from empty.
module bht_update_fifo #(
  parameter int unsigned DW    = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer / storage values for a push and/or pop this cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Register pointers and storage; reset empties the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/bht_update_scheduler.sv
// Branch history table port arbiter: lookups take priority, outcome updates
// are queued and retired as read-modify-write of 2-bit saturating counters.
// Optional starvation guard: define BHT_STALL_GUARD_EN.
module bht_update_scheduler
  import bht_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_STALL  = 8
) (
  input logic                    clk,
  input logic                    rst,
  bht_update_scheduler_if.slave  bus
);

  localparam int unsigned ENTRY_W = ADDR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_STALL < 1) begin : g_cfg_check
    $error("bht_update_scheduler: FIFO_DEPTH must be a power of two >= 2, MAX_STALL >= 1");
  end

  bht_state_e         state_q, state_d;
  logic               pred_valid_q, pred_valid_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  head_addr;
  logic               head_taken;
  logic               guard_trip;

  logic               lk_ready_c, tbl_en_c, tbl_we_c;
  logic [ADDR_W-1:0]  tbl_addr_c;
  logic [1:0]         tbl_wdata_c;

  assign fifo_push = bus.upd_valid && !fifo_full;
  assign {head_addr, head_taken} = head;

  bht_update_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  ({bus.upd_addr, bus.upd_taken}),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state and table-port drive; outputs are silenced while in reset
  always_comb begin
    state_d     = state_q;
    lk_ready_c  = 1'b0;
    tbl_en_c    = 1'b0;
    tbl_we_c    = 1'b0;
    tbl_addr_c  = '0;
    tbl_wdata_c = '0;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_full || guard_trip) begin
          state_d = UPD_RD;
        end else if (bus.lk_valid) begin
          lk_ready_c = 1'b1;
          tbl_en_c   = 1'b1;
          tbl_addr_c = bus.lk_addr;
        end else if (!fifo_empty || fifo_push) begin
          // Include this cycle's push so a lone update reaches UPD_RD next cycle.
          state_d = UPD_RD;
        end
      end
      UPD_RD: begin
        tbl_en_c   = 1'b1;
        tbl_addr_c = head_addr;
        state_d    = UPD_WR;
      end
      UPD_WR: begin
        tbl_en_c    = 1'b1;
        tbl_we_c    = 1'b1;
        tbl_addr_c  = head_addr;
        tbl_wdata_c = head_taken ? sat_inc(bus.tbl_rdata) : sat_dec(bus.tbl_rdata);
        fifo_pop    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      lk_ready_c  = 1'b0;
      tbl_en_c    = 1'b0;
      tbl_we_c    = 1'b0;
      tbl_addr_c  = '0;
      tbl_wdata_c = '0;
      fifo_pop    = 1'b0;
    end
    pred_valid_d = lk_ready_c;
  end

  // FSM state and prediction-valid register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pred_valid_q <= pred_valid_d;
    end
  end

`ifdef BHT_STALL_GUARD_EN
  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Count lookups granted while an update waits; clear when the update starts
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && state_d == UPD_RD) begin
      stall_d = '0;
    end else if (state_q == IDLE && !fifo_empty && lk_ready_c) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign guard_trip = (stall_q == STALL_W'(MAX_STALL));
`else
  assign guard_trip = 1'b0;
`endif

  assign bus.lk_ready   = lk_ready_c;
  assign bus.upd_ready  = !fifo_full;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_valid_q && bus.tbl_rdata[1];
  assign bus.tbl_en     = tbl_en_c;
  assign bus.tbl_we     = tbl_we_c;
  assign bus.tbl_addr   = tbl_addr_c;
  assign bus.tbl_wdata  = tbl_wdata_c;

endmodule
